// File: rtl/wavegen_pkg.sv
// Shared definitions for the DAC SPI writer: frame layout, control bits,
// FSM state encoding and the frame builder.
package wavegen_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;

  // Frame bit positions, MSB first on the wire
  localparam int BIT_AB     = 15;
  localparam int BIT_BUF    = 14;
  localparam int BIT_GA_N   = 13;
  localparam int BIT_SHDN_N = 12;

  // Fixed control bits: unbuffered reference, 1x gain, output active
  localparam logic CTRL_BUF    = 1'b0;
  localparam logic CTRL_GA_N   = 1'b1;
  localparam logic CTRL_SHDN_N = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_LDAC  = 2'd3
  } spi_state_e;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } dac_ch_e;

  function automatic logic [FRAME_W-1:0] build_frame(input dac_ch_e ch,
                                                     input logic [DATA_W-1:0] word);
    logic [FRAME_W-1:0] f;
    f             = '0;
    f[BIT_AB]     = ch;
    f[BIT_BUF]    = CTRL_BUF;
    f[BIT_GA_N]   = CTRL_GA_N;
    f[BIT_SHDN_N] = CTRL_SHDN_N;
    f[DATA_W-1:0] = word;
    return f;
  endfunction

endpackage

// File: rtl/dac_spi_writer_sclk_divider.sv
// SCLK phase timer. While enabled it alternates a low phase and a high phase,
// each CLK_DIV cycles long, and flags the last cycle of each phase so the
// owner can register the SCLK edge on the following clock.
module sclk_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase_hi;

  // Down-counter per phase; reload and flip phase at terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= CNT_LOAD;
      phase_hi <= 1'b0;
    end else if (!en) begin
      cnt      <= CNT_LOAD;
      phase_hi <= 1'b0;
    end else if (cnt == '0) begin
      cnt      <= CNT_LOAD;
      phase_hi <= ~phase_hi;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign rise_stb = en && (cnt == '0) && !phase_hi;
  assign fall_stb = en && (cnt == '0) &&  phase_hi;

endmodule

// File: rtl/dac_spi_writer.sv
// Dual-channel DAC SPI writer: latches both channel words on a sampling
// pulse, shifts A then B out in SPI mode 0 and strobes LDAC once at the end.
//
// state | meaning
// IDLE  | waiting for a sampling pulse with at least one channel enabled
// SHIFT | cs_n low, 16 bits clocked out MSB first
// GAP   | cs_n high between frames / before LDAC
// LDAC  | ldac_n low, both DAC outputs update
module dac_spi_writer
  import wavegen_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 2,
  parameter int LDAC_WIDTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_sampling,
  input  logic              enableA,
  input  logic              enableB,
  input  logic [DATA_W-1:0] dacA_word,
  input  logic [DATA_W-1:0] dacB_word,
  input  logic              overrun_clr,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_mosi,
  output logic              dac_ldac_n,
  output logic              busy,
  output logic              overrun
);

  localparam int TMR_MAX = (CS_GAP > LDAC_WIDTH) ? CS_GAP : LDAC_WIDTH;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(CS_GAP - 1);
  localparam logic [TMR_W-1:0] LDAC_LOAD = TMR_W'(LDAC_WIDTH - 1);

  spi_state_e          state;
  logic [FRAME_W-1:0]  shreg;
  logic [3:0]          bit_cnt;
  logic [TMR_W-1:0]    tmr;
  logic [DATA_W-1:0]   word_b_q;
  logic                b_pending;
  logic                rise_stb;
  logic                fall_stb;
  logic                accept;
  logic [FRAME_W-1:0]  start_frame;
  logic [FRAME_W-1:0]  frame_b;

  // Channel A goes first whenever it is enabled; B follows from the latched word
  assign accept      = clk_sampling && (enableA || enableB);
  assign start_frame = enableA ? build_frame(CH_A, dacA_word) : build_frame(CH_B, dacB_word);
  assign frame_b     = build_frame(CH_B, word_b_q);

  sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state == ST_SHIFT),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Transaction sequencer with registered SPI/LDAC outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      tmr        <= '0;
      word_b_q   <= '0;
      b_pending  <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      dac_ldac_n <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            word_b_q  <= dacB_word;
            b_pending <= enableA && enableB;
            shreg     <= start_frame;
            dac_mosi  <= start_frame[FRAME_W-1];
            bit_cnt   <= 4'd15;
            dac_cs_n  <= 1'b0;
            dac_sclk  <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (rise_stb) begin
            dac_sclk <= 1'b1;
          end else if (fall_stb) begin
            dac_sclk <= 1'b0;
            if (bit_cnt == 4'd0) begin
              dac_cs_n <= 1'b1;
              tmr      <= GAP_LOAD;
              state    <= ST_GAP;
            end else begin
              shreg    <= {shreg[FRAME_W-2:0], 1'b0};
              dac_mosi <= shreg[FRAME_W-2];
              bit_cnt  <= bit_cnt - 4'd1;
            end
          end
        end
        ST_GAP: begin
          if (tmr == '0) begin
            if (b_pending) begin
              b_pending <= 1'b0;
              shreg     <= frame_b;
              dac_mosi  <= frame_b[FRAME_W-1];
              bit_cnt   <= 4'd15;
              dac_cs_n  <= 1'b0;
              state     <= ST_SHIFT;
            end else begin
              dac_ldac_n <= 1'b0;
              tmr        <= LDAC_LOAD;
              state      <= ST_LDAC;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_LDAC: begin
          if (tmr == '0) begin
            dac_ldac_n <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overrun: a pulse while busy sets it, clear wins over set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end else if (clk_sampling && busy) begin
      overrun <= 1'b1;
    end
  end

endmodule
